// File: rtl/kernel_nios2_gen2_0_cpu_mul_combine_if.sv
// Multiply-combine bus: M-stage partial products and control in, W-stage product out.
interface kernel_nios2_gen2_0_cpu_mul_combine_if #(
    parameter int unsigned HALF_W = 16
);
    logic                  M_en;
    logic                  M_mul_valid;
    logic                  M_mul_hi_req;
    logic [2*HALF_W-1:0]   M_mul_cell_p1;
    logic [2*HALF_W-1:0]   M_mul_cell_p2;
    logic [2*HALF_W-1:0]   M_mul_cell_p3;
    logic [HALF_W-1:0]     M_src1_hi;
    logic [HALF_W-1:0]     M_src2_hi;
    logic                  A_flush;
    logic                  mul_stall;
    logic [2*HALF_W-1:0]   W_mul_result;
    logic [2*HALF_W-1:0]   W_mul_hi;
    logic                  W_mul_valid;

    modport slave (
        input  M_en, M_mul_valid, M_mul_hi_req,
        input  M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3,
        input  M_src1_hi, M_src2_hi, A_flush,
        output mul_stall, W_mul_result, W_mul_hi, W_mul_valid
    );

    modport master (
        output M_en, M_mul_valid, M_mul_hi_req,
        output M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3,
        output M_src1_hi, M_src2_hi, A_flush,
        input  mul_stall, W_mul_result, W_mul_hi, W_mul_valid
    );
endinterface

// File: rtl/kernel_nios2_gen2_0_cpu_mul_combine.sv
// Combines 16x16 partial products into the 32-bit MUL result over an M->A->W pipeline.
// Define KERNEL_MUL_HI_EN to build the iterative hi*hi path, its stall and W_mul_hi.
module kernel_nios2_gen2_0_cpu_mul_combine #(
    parameter int unsigned HALF_W   = 16,
    parameter int unsigned HI_ITERS = 16
) (
    input  logic clk,
    input  logic reset_n,
    kernel_nios2_gen2_0_cpu_mul_combine_if.slave bus
);
    localparam int unsigned FULL_W = 2 * HALF_W;

    logic              adv;
    logic              stall;
    logic              a_live;
    logic              A_valid;
    logic              A_hireq;
    logic [FULL_W-1:0] A_p1;
    logic [FULL_W:0]   A_sum;
    logic [HALF_W-1:0] A_ah;
    logic [HALF_W-1:0] A_bh;
    logic [FULL_W:0]   lo_sum;
    logic [FULL_W-1:0] hi_word;
    logic              W_valid_q;
    logic [FULL_W-1:0] W_result_q;
    logic [FULL_W-1:0] W_hi_q;

    assign adv    = bus.M_en & ~stall;
    assign a_live = A_valid & ~bus.A_flush;
    assign lo_sum = {1'b0, A_p1} + {1'b0, A_sum[HALF_W-1:0], {HALF_W{1'b0}}};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            A_valid <= 1'b0;
            A_hireq <= 1'b0;
            A_p1    <= '0;
            A_sum   <= '0;
            A_ah    <= '0;
            A_bh    <= '0;
        end else if (adv) begin
            A_valid <= bus.M_mul_valid;
            A_hireq <= bus.M_mul_valid & bus.M_mul_hi_req;
            A_p1    <= bus.M_mul_cell_p1;
            A_sum   <= {1'b0, bus.M_mul_cell_p2} + {1'b0, bus.M_mul_cell_p3};
            A_ah    <= bus.M_src1_hi;
            A_bh    <= bus.M_src2_hi;
        end else if (bus.A_flush) begin
            // A flushed op is dropped in place so it cannot retire on a later advance
            A_valid <= 1'b0;
            A_hireq <= 1'b0;
        end
    end

`ifdef KERNEL_MUL_HI_EN
    localparam int unsigned CNT_W = (HI_ITERS > 1) ? $clog2(HI_ITERS) : 1;

    typedef enum logic [1:0] {
        HI_IDLE,
        HI_RUN,
        HI_DONE
    } hi_state_t;

    hi_state_t         hi_state;
    hi_state_t         hi_state_nx;
    logic [FULL_W-1:0] acc;
    logic [FULL_W-1:0] acc_nx;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nx;
    logic              hi_start;

    assign stall    = (hi_state == HI_RUN);
    assign hi_start = adv & bus.M_mul_valid & bus.M_mul_hi_req;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi_state <= HI_IDLE;
            acc      <= '0;
            cnt      <= '0;
        end else begin
            hi_state <= hi_state_nx;
            acc      <= acc_nx;
            cnt      <= cnt_nx;
        end
    end

    always_comb begin
        hi_state_nx = hi_state;
        acc_nx      = acc;
        cnt_nx      = cnt;
        unique case (hi_state)
            HI_IDLE: begin
                if (hi_start) begin
                    hi_state_nx = HI_RUN;
                    acc_nx      = '0;
                    cnt_nx      = '0;
                end
            end
            HI_RUN: begin
                if (bus.A_flush) begin
                    hi_state_nx = HI_IDLE;
                end else begin
                    if (A_bh[cnt]) begin
                        acc_nx = acc + (FULL_W'(A_ah) << cnt);
                    end
                    cnt_nx = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(HI_ITERS - 1)) begin
                        hi_state_nx = HI_DONE;
                    end
                end
            end
            HI_DONE: begin
                // The advance that retires this op may capture another hi op; chain into RUN
                if (hi_start) begin
                    hi_state_nx = HI_RUN;
                    acc_nx      = '0;
                    cnt_nx      = '0;
                end else if (adv || bus.A_flush) begin
                    hi_state_nx = HI_IDLE;
                end
            end
            default: hi_state_nx = HI_IDLE;
        endcase
    end

    assign hi_word = A_hireq
                   ? (acc + FULL_W'(A_sum[FULL_W:HALF_W]) + FULL_W'(lo_sum[FULL_W]))
                   : '0;
`else
    logic unused_hi;

    assign stall     = 1'b0;
    assign hi_word   = '0;
    assign unused_hi = ^{A_hireq, A_ah, A_bh, A_sum[FULL_W:HALF_W], lo_sum[FULL_W]};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            W_valid_q  <= 1'b0;
            W_result_q <= '0;
            W_hi_q     <= '0;
        end else if (adv) begin
            W_valid_q <= a_live;
            if (a_live) begin
                W_result_q <= lo_sum[FULL_W-1:0];
                W_hi_q     <= hi_word;
            end
        end
    end

    assign bus.mul_stall    = stall;
    assign bus.W_mul_valid  = W_valid_q;
    assign bus.W_mul_result = W_result_q;
    assign bus.W_mul_hi     = W_hi_q;

endmodule

// File: tb/tb_kernel_nios2_gen2_0_cpu_mul_combine.sv
// Directed self-checking bench for kernel_nios2_gen2_0_cpu_mul_combine (with or without KERNEL_MUL_HI_EN).
module tb_kernel_nios2_gen2_0_cpu_mul_combine;

`ifdef KERNEL_MUL_HI_EN
    localparam int unsigned EXP_STALL  = 16;
    localparam logic        STALL_BIT  = 1'b1;
    localparam int unsigned FLUSH_LEAD = 5;
    localparam logic [31:0] T1_HI      = 32'h0000_0003;
    localparam logic [31:0] T2_HI      = 32'hFFFF_FFFE;
    localparam logic [31:0] T4_HI      = 32'h0000_0015;
`else
    localparam int unsigned EXP_STALL  = 0;
    localparam logic        STALL_BIT  = 1'b0;
    localparam int unsigned FLUSH_LEAD = 0;
    localparam logic [31:0] T1_HI      = 32'h0;
    localparam logic [31:0] T2_HI      = 32'h0;
    localparam logic [31:0] T4_HI      = 32'h0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    int unsigned errors = 0;
    int unsigned checks = 0;

    kernel_nios2_gen2_0_cpu_mul_combine_if #(.HALF_W(16)) bus ();

    kernel_nios2_gen2_0_cpu_mul_combine #(.HALF_W(16), .HI_ITERS(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial forever #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic v, input logic h, input logic [31:0] a, input logic [31:0] b);
        bus.M_mul_valid   = v;
        bus.M_mul_hi_req  = h;
        bus.M_mul_cell_p1 = {16'h0, a[15:0]}  * {16'h0, b[15:0]};
        bus.M_mul_cell_p2 = {16'h0, a[15:0]}  * {16'h0, b[31:16]};
        bus.M_mul_cell_p3 = {16'h0, a[31:16]} * {16'h0, b[15:0]};
        bus.M_src1_hi     = a[31:16];
        bus.M_src2_hi     = b[31:16];
    endtask

    // Issues one op, waits out any stall (bounded), returns the W outputs after it retires.
    task automatic do_single(input logic [31:0] a, input logic [31:0] b, input logic h,
                             output logic [31:0] lo, output logic [31:0] hi,
                             output logic vld, output int unsigned stalls);
        set_op(1'b1, h, a, b);
        bus.M_en = 1'b1;
        tick();
        set_op(1'b0, 1'b0, 32'h0, 32'h0);
        stalls = 0;
        while (bus.mul_stall === 1'b1 && stalls < 100) begin
            tick();
            stalls++;
        end
        tick();
        lo  = bus.W_mul_result;
        hi  = bus.W_mul_hi;
        vld = bus.W_mul_valid;
    endtask

    task automatic test_reset();
        checks++; if (bus.W_mul_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.W_mul_valid); end
        checks++; if (bus.W_mul_result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", bus.W_mul_result); end
        checks++; if (bus.W_mul_hi !== 32'h0) begin errors++; $display("FAIL reset_hi got=%h exp=0", bus.W_mul_hi); end
        checks++; if (bus.mul_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", bus.mul_stall); end
    endtask

    task automatic test_basic();
        logic [31:0] lo, hi;
        logic        vld;
        int unsigned st;
        do_single(32'h0001_0002, 32'h0003_0004, 1'b1, lo, hi, vld, st);
        checks++; if (lo !== 32'h000A_0008) begin errors++; $display("FAIL basic_lo got=%h exp=%h", lo, 32'h000A_0008); end
        checks++; if (hi !== T1_HI) begin errors++; $display("FAIL basic_hi got=%h exp=%h", hi, T1_HI); end
        checks++; if (vld !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", vld); end
        checks++; if (st != EXP_STALL) begin errors++; $display("FAIL basic_stall_cycles got=%0d exp=%0d", st, EXP_STALL); end
    endtask

    task automatic test_carry();
        logic [31:0] lo, hi;
        logic        vld;
        int unsigned st;
        do_single(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, lo, hi, vld, st);
        checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL carry_lo got=%h exp=%h", lo, 32'h0000_0001); end
        checks++; if (hi !== T2_HI) begin errors++; $display("FAIL carry_hi got=%h exp=%h", hi, T2_HI); end
        checks++; if (vld !== 1'b1) begin errors++; $display("FAIL carry_valid got=%b exp=1", vld); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a_tab [4];
        logic [31:0] b_tab [4];
        logic [31:0] e_tab [4];
        a_tab[0] = 32'd3;          b_tab[0] = 32'd5;          e_tab[0] = 32'h0000_000F;
        a_tab[1] = 32'h0002_0000;  b_tab[1] = 32'h0000_0003;  e_tab[1] = 32'h0006_0000;
        a_tab[2] = 32'h0001_0001;  b_tab[2] = 32'h0001_0001;  e_tab[2] = 32'h0002_0001;
        a_tab[3] = 32'h0000_FFFF;  b_tab[3] = 32'h0001_0000;  e_tab[3] = 32'hFFFF_0000;
        bus.M_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) set_op(1'b1, 1'b0, a_tab[i], b_tab[i]);
            else       set_op(1'b0, 1'b0, 32'h0, 32'h0);
            tick();
            checks++; if (bus.mul_stall !== 1'b0) begin errors++; $display("FAIL b2b_stall[%0d] got=%b exp=0", i, bus.mul_stall); end
            if (i >= 1 && i <= 4) begin
                checks++; if (bus.W_mul_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got=%b exp=1", i, bus.W_mul_valid); end
                checks++; if (bus.W_mul_result !== e_tab[i-1]) begin errors++; $display("FAIL b2b_result[%0d] got=%h exp=%h", i, bus.W_mul_result, e_tab[i-1]); end
                checks++; if (bus.W_mul_hi !== 32'h0) begin errors++; $display("FAIL b2b_hi[%0d] got=%h exp=0", i, bus.W_mul_hi); end
            end else if (i == 5) begin
                checks++; if (bus.W_mul_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain_valid got=%b exp=0", bus.W_mul_valid); end
            end
        end
    endtask

    task automatic test_stall();
        int unsigned stalls = 0;
        set_op(1'b1, 1'b1, 32'h0003_0000, 32'h0007_0001);
        bus.M_en = 1'b1;
        tick();
        set_op(1'b1, 1'b0, 32'd3, 32'd5);
        while (bus.mul_stall === 1'b1 && stalls < 100) begin
            checks++;
            if (bus.W_mul_valid !== 1'b0 || bus.W_mul_result !== 32'hFFFF_0000) begin
                errors++;
                $display("FAIL stall_hold[%0d] got=%b/%h exp=0/%h", stalls, bus.W_mul_valid, bus.W_mul_result, 32'hFFFF_0000);
            end
            tick();
            stalls++;
        end
        checks++; if (stalls != EXP_STALL) begin errors++; $display("FAIL stall_cycles got=%0d exp=%0d", stalls, EXP_STALL); end
        tick();
        set_op(1'b0, 1'b0, 32'h0, 32'h0);
        checks++; if (bus.W_mul_result !== 32'h0003_0000) begin errors++; $display("FAIL stall_lo got=%h exp=%h", bus.W_mul_result, 32'h0003_0000); end
        checks++; if (bus.W_mul_hi !== T4_HI) begin errors++; $display("FAIL stall_hi got=%h exp=%h", bus.W_mul_hi, T4_HI); end
        checks++; if (bus.W_mul_valid !== 1'b1) begin errors++; $display("FAIL stall_valid got=%b exp=1", bus.W_mul_valid); end
        tick();
        checks++; if (bus.W_mul_result !== 32'h0000_000F) begin errors++; $display("FAIL stall_next_lo got=%h exp=%h", bus.W_mul_result, 32'h0000_000F); end
        checks++; if (bus.W_mul_hi !== 32'h0) begin errors++; $display("FAIL stall_next_hi got=%h exp=0", bus.W_mul_hi); end
        checks++; if (bus.W_mul_valid !== 1'b1) begin errors++; $display("FAIL stall_next_valid got=%b exp=1", bus.W_mul_valid); end
    endtask

    task automatic test_flush();
        logic [31:0] lo, hi;
        logic        vld;
        int unsigned st;
        set_op(1'b1, 1'b1, 32'h0001_0002, 32'h0003_0004);
        bus.M_en = 1'b1;
        tick();
        set_op(1'b0, 1'b0, 32'h0, 32'h0);
        repeat (FLUSH_LEAD) tick();
        checks++; if (bus.mul_stall !== STALL_BIT) begin errors++; $display("FAIL flush_pre_stall got=%b exp=%b", bus.mul_stall, STALL_BIT); end
        bus.A_flush = 1'b1;
        tick();
        bus.A_flush = 1'b0;
        checks++; if (bus.mul_stall !== 1'b0) begin errors++; $display("FAIL flush_stall got=%b exp=0", bus.mul_stall); end
        checks++; if (bus.W_mul_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", bus.W_mul_valid); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (bus.W_mul_valid !== 1'b0) begin errors++; $display("FAIL flush_after_valid[%0d] got=%b exp=0", i, bus.W_mul_valid); end
            checks++; if (bus.mul_stall !== 1'b0) begin errors++; $display("FAIL flush_after_stall[%0d] got=%b exp=0", i, bus.mul_stall); end
        end
        do_single(32'h0001_0002, 32'h0003_0004, 1'b1, lo, hi, vld, st);
        checks++; if (lo !== 32'h000A_0008) begin errors++; $display("FAIL flush_next_lo got=%h exp=%h", lo, 32'h000A_0008); end
        checks++; if (hi !== T1_HI) begin errors++; $display("FAIL flush_next_hi got=%h exp=%h", hi, T1_HI); end
        checks++; if (vld !== 1'b1) begin errors++; $display("FAIL flush_next_valid got=%b exp=1", vld); end
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] lo, hi;
        logic        vld;
        int unsigned st;
        set_op(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        bus.M_en = 1'b1;
        tick();
        set_op(1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) tick();
        #2 reset_n = 1'b0;
        #1;
        checks++; if (bus.mul_stall !== 1'b0) begin errors++; $display("FAIL rst_mid_stall got=%b exp=0", bus.mul_stall); end
        checks++; if (bus.W_mul_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got=%b exp=0", bus.W_mul_valid); end
        checks++; if (bus.W_mul_result !== 32'h0) begin errors++; $display("FAIL rst_mid_result got=%h exp=0", bus.W_mul_result); end
        checks++; if (bus.W_mul_hi !== 32'h0) begin errors++; $display("FAIL rst_mid_hi got=%h exp=0", bus.W_mul_hi); end
        #3 reset_n = 1'b1;
        do_single(32'h0001_0002, 32'h0003_0004, 1'b1, lo, hi, vld, st);
        checks++; if (lo !== 32'h000A_0008) begin errors++; $display("FAIL rst_next_lo got=%h exp=%h", lo, 32'h000A_0008); end
        checks++; if (hi !== T1_HI) begin errors++; $display("FAIL rst_next_hi got=%h exp=%h", hi, T1_HI); end
        checks++; if (vld !== 1'b1) begin errors++; $display("FAIL rst_next_valid got=%b exp=1", vld); end
        checks++; if (st != EXP_STALL) begin errors++; $display("FAIL rst_next_stall_cycles got=%0d exp=%0d", st, EXP_STALL); end
    endtask

    initial begin
        bus.M_en    = 1'b0;
        bus.A_flush = 1'b0;
        set_op(1'b0, 1'b0, 32'h0, 32'h0);
        #12;
        test_reset();
        reset_n = 1'b1;
        test_basic();
        test_carry();
        test_back_to_back();
        test_stall();
        test_flush();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
